clr_dp_ram: RTL
===============

# clr_dp_ram

Parametrised simple-dual-port RAM: one write port, one read port, on a single clock. It extends the basic register-array RAM with:
- read-enable with a matching valid flag;
- a selectable read-during-write mode;
- an optional output pipeline register;
- a built-in clear sequencer that fills every word with a constant after reset or on request.

It serves as the general storage primitive for buffers and lookup tables elsewhere in the design.

## Interface
Parameters:
- DWIDTH, 16, data word width (>=1)
- DEPTH, 256, number of words (>=2, need not be a power of two); address width AW = $clog2(DEPTH)
- RD_MODE, 0, read-during-write to the same address: 0 = read-first (old data), 1 = write-first (new data)
- OUT_REG, 0, 0 = read latency 1; 1 = extra output register, read latency 2
- CLEAR_VAL, 0, DWIDTH-bit value written to every word by the clear sequencer

Ports:
- aclk  in  1  clock; all logic on rising edge
- areset  in  1  asynchronous, active-high reset
- write_enable  in  1  write strobe
- wr_addr  in  AW  write address
- data_in  in  DWIDTH  write data
- rd_enable  in  1  read strobe
- rd_addr  in  AW  read address
- data_out  out  DWIDTH  read data
- data_valid  out  1  data_out holds the result of a read this cycle (one-cycle pulse per read)
- clear_req  in  1  request a full-array clear
- busy  out  1  clear sequencer active; user port accesses are ignored

## Operation
- Clock and reset: one clock, aclk. Reset areset is asynchronous and active-high.
- Clear FSM states: IDLE and CLEAR.
  - areset forces CLEAR with clear counter = 0.
  - In CLEAR, each edge writes CLEAR_VAL to ram[counter] and increments the counter.
  - After the edge that writes address DEPTH-1, the FSM goes to IDLE.
  - In IDLE, clear_req=1 at an edge moves the FSM to CLEAR with counter = 0.
- busy = (state == CLEAR). It is registered, not combinational from clear_req.
- While busy=1:
  - write_enable and rd_enable are ignored: no user write, no data_valid.
  - clear_req is ignored; a running clear is not restarted.
- Writes (IDLE only): if write_enable=1 and wr_addr < DEPTH, then ram[wr_addr] <= data_in. A write with wr_addr >= DEPTH is dropped.
- Reads (IDLE only):
  - If rd_enable=1, the word at rd_addr is captured.
  - With rd_addr >= DEPTH, the read returns CLEAR_VAL and data_valid still pulses.
- data_out holds its last value when no read completes; it does not follow rd_addr without rd_enable.
- Read-during-write to the same address in the same cycle:
  - RD_MODE=0: returns the pre-write content.
  - RD_MODE=1: returns data_in.
  - Different addresses never interact.
- The clear counter is AW+1 bits wide, so termination at DEPTH-1 is exact for non-power-of-two DEPTH.

## Timing
- Reset values (asynchronous):
  - data_out = 0, data_valid = 0, busy = 1, state = CLEAR, counter = 0.
  - Also with OUT_REG=1, the pipeline stage is cleared to 0 and its valid to 0.
  - RAM contents are not reset directly; the clear sequencer fills them.
- Clear duration:
  - The first rising edge after areset deasserts writes address 0.
  - Edge k writes address k-1, for k = 1..DEPTH.
  - busy falls after edge DEPTH; edge DEPTH+1 is the first edge that accepts user accesses.
  - For a clear_req sampled at edge 0: busy=1 after edge 0, addresses 0..DEPTH-1 are written at edges 1..DEPTH, and busy=0 after edge DEPTH.
- Read latency:
  - rd_enable sampled at edge N gives data_out/data_valid valid after edge N+1 (OUT_REG=0) or after edge N+2 (OUT_REG=1).
  - Back-to-back reads give one result per cycle at full throughput.
- A read sampled on the edge where busy goes 0→1 completes normally: it was accepted in IDLE.
- areset mid-clear or mid-read:
  - Any in-flight read result is discarded: data_valid = 0.
  - The clear restarts from address 0.
- A write at edge N is visible to a read issued at edge N+1. Same-edge visibility follows RD_MODE.

## Test plan
- Reset and auto-clear:
  - Stimulus: DEPTH=256, DWIDTH=16, CLEAR_VAL=16'hA5A5. Write random data while busy=1, then wait for busy=0 (exactly 256 cycles after reset release). Read addresses 0, 128 and 255.
  - Required: all reads return 16'hA5A5 with data_valid=1, latency 1; no ignored write took effect.
- Write/read latency:
  - Stimulus: write 16'h1234 to address 7, next cycle rd_enable with rd_addr=7.
  - Required: 16'h1234 and data_valid one cycle later (OUT_REG=0) or two cycles later (OUT_REG=1). data_out holds while rd_enable=0.
- Read-during-write:
  - Stimulus: ram[3]=16'h0001, then in the same cycle write 16'h00FF to address 3 and read address 3.
  - Required: RD_MODE=0 returns 16'h0001; RD_MODE=1 returns 16'h00FF. A following read returns 16'h00FF in both modes.
- Non-power-of-two depth:
  - Stimulus: DEPTH=5. Issue clear_req and count the cycles with busy high. Write to address 6, then read addresses 4 and 6.
  - Required: busy high for exactly 5 cycles. The write to address 6 is dropped; reading 6 returns CLEAR_VAL with data_valid=1; address 4 is cleared.
- Reset mid-clear:
  - Stimulus: assert areset asynchronously after 100 clear cycles.
  - Required: data_out=0, data_valid=0, busy=1 immediately. The clear restarts and takes the full DEPTH cycles.
- clear_req while busy:
  - Stimulus: pulse clear_req during an active clear.
  - Required: no extension; busy falls at the original cycle.

Source files
------------

// File: rtl/clr_dp_ram_if.sv
`default_nettype none
// ============================================================================
// Module   : clr_dp_ram_if
// Brief    : Write/read/clear port bundle for the clr_dp_ram storage primitive.
// Revision : 1.0 - initial release
// ============================================================================
interface clr_dp_ram_if #(
    parameter int DWIDTH = 16,
    parameter int AW     = 8
);
    logic              write_enable;
    logic [AW-1:0]     wr_addr;
    logic [DWIDTH-1:0] data_in;
    logic              rd_enable;
    logic [AW-1:0]     rd_addr;
    logic [DWIDTH-1:0] data_out;
    logic              data_valid;
    logic              clear_req;
    logic              busy;

    modport master (
        output write_enable, wr_addr, data_in, rd_enable, rd_addr, clear_req,
        input  data_out, data_valid, busy
    );

    modport slave (
        input  write_enable, wr_addr, data_in, rd_enable, rd_addr, clear_req,
        output data_out, data_valid, busy
    );
endinterface
`default_nettype wire

// File: rtl/clr_dp_ram.sv
`default_nettype none
// ============================================================================
// Module   : clr_dp_ram
// Brief    : Simple dual-port RAM with read valid, selectable read-during-write,
//            optional output register and a built-in clear sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module clr_dp_ram #(
    parameter int                DWIDTH    = 16,
    parameter int                DEPTH     = 256,
    parameter int                RD_MODE   = 0,
    parameter int                OUT_REG   = 0,
    parameter logic [DWIDTH-1:0] CLEAR_VAL = '0
) (
    input  wire          aclk,
    input  wire          areset,
    clr_dp_ram_if.slave  bus
);
    localparam int            AW      = $clog2(DEPTH);
    localparam logic [AW:0]   c_DEPTH = (AW+1)'(DEPTH);
    localparam logic [AW:0]   c_LAST  = (AW+1)'(DEPTH - 1);
    localparam logic [AW:0]   c_ONE   = (AW+1)'(1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [AW:0]       r_cnt;
    logic [AW:0]       w_cnt_nxt;

    logic [DWIDTH-1:0] r_mem [DEPTH];

    logic              w_idle;
    logic              w_wr_ok;
    logic              w_rd_ok;
    logic              w_rd_in_range;
    logic              w_mem_we;
    logic [AW-1:0]     w_mem_addr;
    logic [DWIDTH-1:0] w_mem_din;
    logic [DWIDTH-1:0] w_rd_word;

    logic [DWIDTH-1:0] r_rd_data;
    logic              r_rd_valid;

    // ------------------------------------------------------------------
    // Clear sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state <= S_CLEAR;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_CLEAR: begin
                if (r_cnt == c_LAST) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + c_ONE;
                end
            end
            default: begin
                if (bus.clear_req) begin
                    w_state_nxt = S_CLEAR;
                    w_cnt_nxt   = '0;
                end
            end
        endcase
    end

    assign w_idle   = (r_state == S_IDLE);
    assign bus.busy = (r_state == S_CLEAR);

    // ------------------------------------------------------------------
    // Storage: the clear sequencer owns the write port while busy
    // ------------------------------------------------------------------
    assign w_wr_ok       = w_idle && bus.write_enable && ({1'b0, bus.wr_addr} < c_DEPTH);
    assign w_rd_ok       = w_idle && bus.rd_enable;
    assign w_rd_in_range = ({1'b0, bus.rd_addr} < c_DEPTH);

    assign w_mem_we   = !w_idle || w_wr_ok;
    assign w_mem_addr = w_idle ? bus.wr_addr : r_cnt[AW-1:0];
    assign w_mem_din  = w_idle ? bus.data_in : CLEAR_VAL;

    always_ff @(posedge aclk) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_din;
        end
    end

    // Read-first falls out of the non-blocking array update; write-first needs the bypass.
    always_comb begin
        w_rd_word = CLEAR_VAL;
        if (w_rd_in_range) begin
            if ((RD_MODE != 0) && w_wr_ok && (bus.wr_addr == bus.rd_addr)) begin
                w_rd_word = bus.data_in;
            end else begin
                w_rd_word = r_mem[bus.rd_addr];
            end
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_ok;
            if (w_rd_ok) begin
                r_rd_data <= w_rd_word;
            end
        end
    end

    // ------------------------------------------------------------------
    // Optional output pipeline stage
    // ------------------------------------------------------------------
    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DWIDTH-1:0] r_pipe_data;
            logic              r_pipe_valid;

            always_ff @(posedge aclk or posedge areset) begin
                if (areset) begin
                    r_pipe_data  <= '0;
                    r_pipe_valid <= 1'b0;
                end else begin
                    r_pipe_valid <= r_rd_valid;
                    if (r_rd_valid) begin
                        r_pipe_data <= r_rd_data;
                    end
                end
            end

            assign bus.data_out   = r_pipe_data;
            assign bus.data_valid = r_pipe_valid;
        end else begin : g_no_out_reg
            assign bus.data_out   = r_rd_data;
            assign bus.data_valid = r_rd_valid;
        end
    endgenerate

endmodule
`default_nettype wire
